// File: rtl/instr_seq_ctrl.sv
// Sequencing controller for the instruction register file: round-robin load
// arbitration, circular read/write pointers, occupancy tracking and in-order issue.
module instr_seq_ctrl #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned PTR_W = 5,
  parameter int unsigned OPC_W = 5,
  parameter int unsigned OPD_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic             a_req,
  input  logic [OPC_W-1:0] a_opc,
  input  logic [OPD_W-1:0] a_opa,
  input  logic [OPD_W-1:0] a_opb,
  output logic             a_gnt,
  input  logic             b_req,
  input  logic [OPC_W-1:0] b_opc,
  input  logic [OPD_W-1:0] b_opa,
  input  logic [OPD_W-1:0] b_opb,
  output logic             b_gnt,
  output logic             load_en,
  output logic [OPC_W-1:0] opcode,
  output logic [OPD_W-1:0] operand_a,
  output logic [OPD_W-1:0] operand_b,
  output logic [PTR_W-1:0] write_pointer,
  output logic [PTR_W-1:0] read_pointer,
  input  logic             valid,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic             reg_reset_n,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             err,
  output logic [1:0]       state
);

  localparam logic [PTR_W:0] FullCount = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             err_q, err_d;
  logic             last_b_q, last_b_d;
  logic             run;
  logic             grant_ok;
  logic             fire;

  assign run      = (state_q == StRun);
  assign full     = (count_q == FullCount);
  assign empty    = (count_q == '0);
  assign grant_ok = run & ~full;

  // On a tie the requester that did not win last time takes the port.
  assign a_gnt   = grant_ok & a_req & (~b_req | last_b_q);
  assign b_gnt   = grant_ok & b_req & (~a_req | ~last_b_q);
  assign load_en = a_gnt | b_gnt;

  assign opcode    = b_gnt ? b_opc : a_opc;
  assign operand_a = b_gnt ? b_opa : a_opa;
  assign operand_b = b_gnt ? b_opb : a_opb;

  assign write_pointer = wr_ptr_q;
  assign read_pointer  = rd_ptr_q;
  assign issue_valid   = run & ~empty & valid;
  assign fire          = issue_valid & issue_ready;

  assign count = count_q;
  assign err   = err_q;
  assign state = state_q;

  // StFlush is the only state with bit 1 set, so this decode is a single flop bit.
  assign reg_reset_n = ~reset & ~state_q[1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (flush) begin
          state_d = StFlush;
        end else if (enable) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StFlush;
        end else if (!enable) begin
          state_d = StIdle;
        end
      end
      StFlush: state_d = enable ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (state_q == StFlush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (load_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (fire) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({load_en, fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    err_d    = err_q | (run & ~empty & ~valid);
    last_b_d = last_b_q;
    if (b_gnt) begin
      last_b_d = 1'b1;
    end else if (a_gnt) begin
      last_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_instr_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       flush;
  logic       a_req, b_req;
  logic [4:0] a_opc, b_opc;
  logic [3:0] a_opa, a_opb, b_opa, b_opb;
  logic       a_gnt, b_gnt;
  logic       load_en;
  logic [4:0] opcode;
  logic [3:0] operand_a, operand_b;
  logic [4:0] write_pointer, read_pointer;
  logic       valid;
  logic       issue_valid;
  logic       issue_ready;
  logic       reg_reset_n;
  logic [5:0] count;
  logic       full, empty;
  logic       err;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  // Reference model: the queue contents themselves, plus pointer positions.
  int          m_state;
  int          m_wr, m_rd;
  logic        m_last_b;
  logic        m_err;
  logic [12:0] mq[$];
  logic [12:0] reg_mem[32];

  instr_seq_ctrl #(
    .DEPTH(32),
    .PTR_W(5),
    .OPC_W(5),
    .OPD_W(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .flush        (flush),
    .a_req        (a_req),
    .a_opc        (a_opc),
    .a_opa        (a_opa),
    .a_opb        (a_opb),
    .a_gnt        (a_gnt),
    .b_req        (b_req),
    .b_opc        (b_opc),
    .b_opa        (b_opa),
    .b_opb        (b_opb),
    .b_gnt        (b_gnt),
    .load_en      (load_en),
    .opcode       (opcode),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .write_pointer(write_pointer),
    .read_pointer (read_pointer),
    .valid        (valid),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .reg_reset_n  (reg_reset_n),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .err          (err),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_wr     = 0;
    m_rd     = 0;
    m_last_b = 1'b1;
    m_err    = 1'b0;
    mq.delete();
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic        ea, eb, eiv, erun, eempty, efull;
    logic [12:0] fld;
    logic        cap_we;
    logic [4:0]  cap_idx;
    logic [12:0] cap_data;
    ea = 0; eb = 0; eiv = 0; erun = 0; eempty = 1; efull = 0; fld = '0;
    @(negedge clk);
    cap_we   = load_en;
    cap_idx  = write_pointer;
    cap_data = {opcode, operand_a, operand_b};
    if (reset) begin
      chk("rst_a_gnt", a_gnt, 0);
      chk("rst_b_gnt", b_gnt, 0);
      chk("rst_load_en", load_en, 0);
      chk("rst_issue_valid", issue_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_state", state, 0);
      chk("rst_reg_reset_n", reg_reset_n, 0);
    end else begin
      erun   = (m_state == 1);
      eempty = (mq.size() == 0);
      efull  = (mq.size() == 32);
      ea     = erun && !efull && a_req && (!b_req || m_last_b);
      eb     = erun && !efull && b_req && (!a_req || !m_last_b);
      eiv    = erun && !eempty && valid;
      fld    = eb ? {b_opc, b_opa, b_opb} : {a_opc, a_opa, a_opb};
      chk("a_gnt", a_gnt, int'(ea));
      chk("b_gnt", b_gnt, int'(eb));
      chk("load_en", load_en, int'(ea || eb));
      chk("wdata", {opcode, operand_a, operand_b}, fld);
      chk("write_pointer", write_pointer, m_wr);
      chk("read_pointer", read_pointer, m_rd);
      chk("count", count, mq.size());
      chk("full", full, int'(efull));
      chk("empty", empty, int'(eempty));
      chk("issue_valid", issue_valid, int'(eiv));
      chk("state", state, m_state);
      chk("err", err, int'(m_err));
      chk("reg_reset_n", reg_reset_n, int'(m_state != 2));
      if (eiv && issue_ready) chk("issue_data", reg_mem[m_rd], mq[0]);
    end
    @(posedge clk);
    if (cap_we) reg_mem[cap_idx] = cap_data;
    if (reset) begin
      model_reset();
    end else if (m_state == 2) begin
      mq.delete();
      m_wr    = 0;
      m_rd    = 0;
      m_state = enable ? 1 : 0;
    end else begin
      if (erun && !eempty && !valid) m_err = 1'b1;
      if (ea || eb) begin
        mq.push_back(fld);
        m_wr     = (m_wr + 1) % 32;
        m_last_b = eb;
      end
      if (eiv && issue_ready) begin
        void'(mq.pop_front());
        m_rd = (m_rd + 1) % 32;
      end
      m_state = flush ? 2 : (enable ? 1 : 0);
    end
    #1;
  endtask

  task automatic idle_inputs();
    enable = 0; flush = 0; a_req = 0; b_req = 0; issue_ready = 0; valid = 1;
    a_opc = 0; a_opa = 0; a_opb = 0; b_opc = 0; b_opa = 0; b_opb = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    model_reset();
    step();
    reset = 0;
  endtask

  task automatic start_run();
    idle_inputs();
    do_reset();
    enable = 1;
    step();
  endtask

  initial begin
    reset = 1;
    idle_inputs();

    // First load, no consumer.
    start_run();
    a_req = 1; a_opc = 3; a_opa = 5; a_opb = 9;
    #1;
    chk("t1_a_gnt", a_gnt, 1);
    chk("t1_wp", write_pointer, 0);
    step();
    a_req = 0;
    #1;
    chk("t1_count", count, 1);
    chk("t1_issue_valid", issue_valid, 1);
    chk("t1_rp", read_pointer, 0);
    chk("t1_a_gnt_off", a_gnt, 0);

    // Held dual requests alternate, A first.
    start_run();
    a_req = 1; b_req = 1; a_opc = 1; b_opc = 2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_a_gnt", a_gnt, int'(i % 2 == 0));
      chk("t2_b_gnt", b_gnt, int'(i % 2 == 1));
      chk("t2_wp", write_pointer, i);
      step();
    end
    b_req = 0;
    #1;
    chk("t2_count", count, 4);

    // Fill to 32, then issue one and reload into the wrapped slot.
    for (int i = 0; i < 28; i++) begin
      a_opc = 5'(i);
      step();
    end
    #1;
    chk("t3_full", full, 1);
    chk("t3_no_gnt", a_gnt, 0);
    step();
    a_req = 0; issue_ready = 1;
    step();
    issue_ready = 0; a_req = 1;
    #1;
    chk("t3_wp_wrap", write_pointer, 0);
    chk("t3_gnt", a_gnt, 1);
    chk("t3_count31", count, 31);
    step();
    a_req = 0;
    #1;
    chk("t3_count32", count, 32);

    // Simultaneous load and issue leaves count unchanged.
    start_run();
    a_req = 1;
    repeat (5) step();
    issue_ready = 1;
    step();
    a_req = 0; issue_ready = 0;
    #1;
    chk("t4_count", count, 5);
    chk("t4_rp", read_pointer, 1);
    chk("t4_wp", write_pointer, 6);

    // Flush at count 7.
    start_run();
    a_req = 1;
    repeat (7) step();
    a_req = 0; flush = 1;
    step();
    flush = 0; a_req = 1;
    #1;
    chk("t5_state", state, 2);
    chk("t5_reg_reset_n", reg_reset_n, 0);
    chk("t5_no_gnt", a_gnt, 0);
    step();
    a_req = 0;
    #1;
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_wp", write_pointer, 0);
    chk("t5_rp", read_pointer, 0);
    chk("t5_run", state, 1);

    // Valid mismatch makes err sticky; then async reset mid-grant.
    start_run();
    a_req = 1;
    repeat (2) step();
    a_req = 0; valid = 0;
    #1;
    chk("t6_issue_valid", issue_valid, 0);
    step();
    valid = 1;
    #1;
    chk("t6_err", err, 1);
    step();
    #1;
    chk("t6_err_sticky", err, 1);
    a_req = 1;
    #1;
    chk("t6_gnt", a_gnt, 1);
    reset = 1;
    #1;
    chk("t6_rst_gnt", a_gnt, 0);
    chk("t6_rst_load_en", load_en, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_state", state, 0);
    chk("t6_rst_reg_reset_n", reg_reset_n, 0);
    chk("t6_rst_wp", write_pointer, 0);
    model_reset();
    step();
    reset = 0;

    // Randomized traffic in alternating fill/drain phases.
    for (int c = 0; c < 4000; c++) begin
      bit fill;
      fill = ((c / 150) % 2) == 0;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        enable      = ($urandom_range(0, 15) != 0);
        flush       = ($urandom_range(0, 79) == 0);
        a_req       = ($urandom_range(0, 99) < (fill ? 80 : 20));
        b_req       = ($urandom_range(0, 99) < (fill ? 80 : 20));
        issue_ready = ($urandom_range(0, 99) < (fill ? 15 : 80));
        valid       = ($urandom_range(0, 299) != 0);
        a_opc = 5'($urandom); a_opa = 4'($urandom); a_opb = 4'($urandom);
        b_opc = 5'($urandom); b_opa = 4'($urandom); b_opb = 4'($urandom);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_seq_ctrl.md
Name: instr_seq_ctrl

Overview:
- Sequencing controller for the instruction register file.
- Arbitrates two load requesters (A, B) onto the single register write port with round-robin priority.
- Manages write and read pointers as a circular queue, tracks occupancy, and issues stored instructions in order through a valid/ready handshake.
- Drives the register's active-low reset for flush, and cross-checks the register's per-entry valid flag.

Parameters:
- DEPTH, 32, number of register entries (power of 2)
- PTR_W, 5, pointer width, log2(DEPTH)
- OPC_W, 5, opcode width
- OPD_W, 4, operand width (each of op_a, op_b)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset; one clock; reset is asynchronous and active-high
- enable  in  1  run control
- flush  in  1  discard all queued entries (single-cycle pulse)
- a_req  in  1  requester A load request
- a_opc, a_opa, a_opb  in  OPC_W/OPD_W/OPD_W  requester A instruction fields
- a_gnt  out  1  requester A granted this cycle
- b_req, b_opc, b_opa, b_opb, b_gnt  same as A, requester B
- load_en  out  1  register write enable
- opcode, operand_a, operand_b  out  OPC_W/OPD_W/OPD_W  muxed write data
- write_pointer  out  PTR_W  register write index
- read_pointer  out  PTR_W  register read index
- valid  in  1  register valid flag at read_pointer
- issue_valid  out  1  head instruction available
- issue_ready  in  1  consumer accepts head
- reg_reset_n  out  1  active-low reset to the register file
- count  out  PTR_W+1  occupancy, 0..DEPTH
- full, empty  out  1  count==DEPTH, count==0
- err  out  1  sticky valid-mismatch flag
- state  out  2  IDLE=0, RUN=1, FLUSH=2

Behaviour:
- Reset values: state=IDLE, wr_ptr=rd_ptr=0, count=0, err=0, last_grant=B (A wins first tie), empty=1, full=0; gnt/load_en/issue_valid=0; reg_reset_n=0 while reset is high.
- FSM. flush has priority over enable.
  - IDLE: goes to FLUSH if flush, else to RUN if enable.
  - RUN: goes to FLUSH if flush, else to IDLE if !enable.
  - FLUSH: lasts exactly one cycle, then goes to RUN if enable, else IDLE.
- FLUSH cycle: no grants, no issue; reg_reset_n=0 (decoded from the state register only, glitch-free); wr_ptr, rd_ptr and count cleared to 0 on exit. err is not cleared.
- Grant (combinational, RUN and !full only):
  - Single requester: granted.
  - Both requesting: the requester that is not last_grant wins.
  - At most one gnt per cycle.
  - last_grant updates on every grant.
- load_en = a_gnt|b_gnt. opcode/operand outputs are muxed from the granted requester, else hold A's fields. write_pointer = wr_ptr. The register captures data at the same edge that increments wr_ptr (mod DEPTH).
- Requester holds its fields while req=1; gnt is its one-cycle acknowledge. A request held across multiple cycles loads one entry per grant.
- issue_valid = RUN & !empty & valid; read_pointer = rd_ptr (register is combinational read, zero latency). On issue_valid & issue_ready: rd_ptr++ (mod DEPTH).
- count: +1 on load only, −1 on issue only, unchanged when both occur in one cycle. Load into a full queue is impossible (no grant); a grant is allowed on the cycle a full queue issues? No: full blocks grants regardless of issue.
- Pointers wrap DEPTH−1 → 0 silently.
- err set when state==RUN & !empty & !valid; sticky until reset.
- IDLE retains pointers/count; issue and grants are frozen.
- Async reset mid-transfer: immediate return to reset values; in-flight grant is lost.

Test Plan:
- Reset, enable=1, A loads opc=3,opa=5,opb=9 with issue_ready=0 → a_gnt 1 cycle, write_pointer=0, count=1, issue_valid=1 with read_pointer=0.
- a_req and b_req held for 4 cycles → grants alternate A,B,A,B; write_pointer 0..3; count=4.
- Load 32 entries → full=1; further a_req gets no gnt. Then issue 1 and load 1 → write_pointer wraps to 0, count=32.
- issue_ready=1 with simultaneous A load at count=5 → count stays 5; rd_ptr and wr_ptr each +1.
- flush at count=7 → one cycle with state=2 and reg_reset_n=0; then count=0, empty=1, pointers 0, RUN.
- Register valid forced 0 while count=2 in RUN → issue_valid=0, err=1 and stays set after valid returns to 1. Async reset asserted mid-grant → all outputs at reset values within the same cycle.
